// File: rtl/adder_bsr_chain.sv
// Boundary-scan register around an adder: scan cells drive the adder inputs and
// observe its outputs. TAP DR strobes act as clock enables on the system clock.
module adder_bsr_chain #(
    parameter int BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture_dr,
    input  logic                 shift_dr,
    input  logic                 update_dr,
    input  logic                 mode,
    input  logic                 tdi,
    output logic                 tdo,
    input  logic [BIT_WIDTH-1:0] sys_a,
    input  logic [BIT_WIDTH-1:0] sys_b,
    input  logic                 sys_cin,
    output logic [BIT_WIDTH-1:0] a,
    output logic [BIT_WIDTH-1:0] b,
    output logic                 carry_in,
    input  logic [BIT_WIDTH-1:0] sum,
    input  logic                 overflow,
    output logic [BIT_WIDTH-1:0] sys_sum,
    output logic                 sys_overflow
);

    localparam int W = BIT_WIDTH;
    localparam int N = 3 * W + 2;

    logic [N-1:0] sr;
    logic [N-1:0] ur;
    logic [N-1:0] cap_val;

    // Input cells capture what the adder actually sees, i.e. after the mode mux.
    assign cap_val = {overflow, sum, carry_in, b, a};
    assign tdo     = sr[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
            ur <= '0;
        end else begin
            if (capture_dr) begin
                sr <= cap_val;
            end else if (shift_dr) begin
                sr <= {tdi, sr[N-1:1]};
            end
            if (update_dr) begin
                ur <= sr;
            end
        end
    end

    always_comb begin
        a            = sys_a;
        b            = sys_b;
        carry_in     = sys_cin;
        sys_sum      = sum;
        sys_overflow = overflow;
        if (mode) begin
            a            = ur[W-1:0];
            b            = ur[2*W-1:W];
            carry_in     = ur[2*W];
            sys_sum      = ur[3*W:2*W+1];
            sys_overflow = ur[3*W+1];
        end
    end

endmodule

// File: doc/adder_bsr_chain.md
Name: adder_bsr_chain

Overview:
- Boundary-scan register (BSR) for the adder_nbit DUT; it is the tester side of the adder interface.
- Drives the adder inputs (a, b, carry_in) from scan cells and captures the adder outputs (sum, overflow) into scan cells.
- Sits between functional logic and the adder, and is controlled by single-cycle DR-phase strobes from the JTAG TAP controller.
- Runs on the system clock, with the TAP strobes used as clock enables.

Parameters:
- BIT_WIDTH, 4, adder operand width W. Chain length N = 3W+2 (14 at default).

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- capture_dr  input  1  one-cycle strobe: load parallel values into the shift stage.
- shift_dr  input  1  per cycle: shift the chain one bit toward tdo.
- update_dr  input  1  one-cycle strobe: copy the shift stage into the update stage.
- mode  input  1  1 = test (cells drive the pins), 0 = functional passthrough.
- tdi  input  1  serial scan in.
- tdo  output  1  serial scan out; equals sr[0].
- sys_a  input  W  functional operand a.
- sys_b  input  W  functional operand b.
- sys_cin  input  1  functional carry in.
- a  output  W  to adder a.
- b  output  W  to adder b.
- carry_in  output  1  to adder carry_in.
- sum  input  W  from adder sum.
- overflow  input  1  from adder overflow.
- sys_sum  output  W  to functional logic.
- sys_overflow  output  1  to functional logic.

Behaviour:
- Shift stage sr[N-1:0] and update stage ur[N-1:0] are both registers.
- Cell map:
  - sr[W-1:0] = a
  - sr[2W-1:W] = b
  - sr[2W] = carry_in
  - sr[3W:2W+1] = sum
  - sr[3W+1] = overflow
- ur uses the same map as sr.
- Reset (rst=1 at an edge): sr=0 and ur=0. tdo=0. With mode=0 the outputs equal the sys_* and adder values.
- rst has priority over every strobe. A reset mid-shift discards the partial chain contents.
- capture_dr=1:
  - Input cells load the values currently driven on a, b, carry_in (after the mux).
  - sr[3W:2W+1] <= sum, sr[3W+1] <= overflow.
- shift_dr=1 (and capture_dr=0): sr <= {tdi, sr[N-1:1]}.
  - Bits leave LSB first (tdo = a[0] first).
  - The first bit shifted in lands in sr[0] after N shifts.
- capture_dr and shift_dr both high: capture wins and no shift occurs.
- update_dr=1: ur <= sr, using sr as it was before the same edge.
  - An update in the same cycle as a capture or shift uses the pre-edge sr.
- Output mux, combinational from registers and inputs:
  - mode=1: a=ur[W-1:0], b=ur[2W-1:W], carry_in=ur[2W], sys_sum=ur[3W:2W+1], sys_overflow=ur[3W+1].
  - mode=0: a=sys_a, b=sys_b, carry_in=sys_cin, sys_sum=sum, sys_overflow=overflow.
- Shifting never disturbs the pin outputs. Only update_dr changes ur.
- The mode=1 sys outputs give EXTEST-style isolation of the downstream logic.
- Adder latency is 1 cycle: capture_dr must be asserted at least 1 cycle after a/b/carry_in become stable. A capture earlier than that samples the old sum; this is legal and is not flagged.
- tdo is valid in the cycle after each shift edge. No other latency applies.
- Idle (no strobes): sr and ur hold.

Test Plan:
- Reset: drive rst=1 for 2 cycles, then N idle cycles with shift_dr=0 -> tdo=0, ur=0. With mode=1, a=0, b=0, carry_in=0, sys_sum=0.
- Passthrough: mode=0, sys_a=7, sys_b=2, sys_cin=1, adder sum=A -> a=7, b=2, carry_in=1, sys_sum=A, sys_overflow=overflow. Continuous shifting does not affect these.
- Intest add:
  - Shift in 14 bits with a=3, b=5, cin=1 (rest 0), LSB first. Pulse update_dr, set mode=1 -> a=3, b=5, carry_in=1.
  - Wait 1 cycle, capture, shift 14 -> tdo sequence 1,1,0,0, 1,0,1,0, 1, 1,0,0,1, 0 (sum=9, overflow=0).
- Overflow: load a=F, b=F, cin=1, update, capture after 1 cycle, shift out -> sum field F, overflow bit 1.
- Simultaneous strobes: capture_dr=1 with shift_dr=1 -> sr equals captured values with no shift. update_dr in the same cycle -> ur takes the old sr.
- Reset mid-operation: rst after 6 of 14 shifts -> sr=0 and ur=0 the next cycle. A subsequent full scan behaves as it does after a fresh reset.
